frame_buf_multi: RTL and testbench

Parametrised multi-frame successor to the single-buffer frame buffer. It holds NUM_BUFS frame slots of BUF_SIZE words each in one internal memory. A writer fills slots in round-robin order, and a slot becomes readable only once complete. A reader drains complete frames in order, so the display/read path never sees a partially written frame. Writer and reader both run on wr_clk.

---
 rtl/frame_buf_multi.sv | 170 +++++++++++++++++
 tb/tb_frame_buf_multi.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_buf_multi.sv
// Multi-slot frame buffer: the writer fills slots round-robin and the reader
// drains only complete frames, oldest first. Single clock domain (wr_clk).
module frame_buf_multi #(
   parameter int DATA_WIDTH = 32,
   parameter int BUF_SIZE   = 500,
   parameter int NUM_BUFS   = 2,
   parameter int DROP_MODE  = 0,
   localparam int IDX_W = (NUM_BUFS > 1) ? $clog2(NUM_BUFS) : 1,
   localparam int OFS_W = $clog2(BUF_SIZE),
   localparam int CNT_W = $clog2(NUM_BUFS + 1)
) (
   input  logic                  wr_clk,
   input  logic                  reset,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic                  wr_rdy,
   output logic                  wr_frame_done,
   input  logic                  rd_en,
   output logic                  rd_rdy,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   output logic                  rd_last,
   output logic [CNT_W-1:0]      frames_avail,
   output logic [15:0]           drop_cnt
);

   localparam int DEPTH  = NUM_BUFS * BUF_SIZE;
   localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [OFS_W-1:0] OFS_LAST = OFS_W'(BUF_SIZE - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_BUFS - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_BUFS);

   typedef enum logic [1:0] {W_IDLE, W_FILL, W_DROP} w_state_t;
   typedef enum logic {R_IDLE, R_READ} r_state_t;

   w_state_t w_state, w_next;
   r_state_t r_state, r_next;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [IDX_W-1:0]  wr_idx, rd_idx;
   logic [OFS_W-1:0]  wr_ofs, rd_ofs;
   logic [ADDR_W-1:0] wr_addr, rd_addr;
   logic              full;
   logic              w_store, w_end;
   logic              r_issue, r_end;
   logic              frame_commit, frame_drop;

   assign full    = (frames_avail == CNT_FULL);
   assign wr_addr = ADDR_W'(wr_idx) * ADDR_W'(BUF_SIZE) + ADDR_W'(wr_ofs);
   assign rd_addr = ADDR_W'(rd_idx) * ADDR_W'(BUF_SIZE) + ADDR_W'(rd_ofs);
   assign rd_rdy  = (frames_avail != '0) || (r_state == R_READ);

   // The slot is claimed in W_IDLE, so a word presented there is offset 0.
   always_comb begin
      w_next  = w_state;
      wr_rdy  = 1'b0;
      w_store = 1'b0;
      w_end   = 1'b0;
      unique case (w_state)
         W_IDLE: begin
            if (!full) begin
               wr_rdy  = 1'b1;
               w_store = wr_en;
               w_next  = W_FILL;
            end else if (DROP_MODE != 0) begin
               wr_rdy = 1'b1;
               w_next = W_DROP;
            end
         end
         W_FILL: begin
            wr_rdy  = 1'b1;
            w_store = wr_en;
            w_end   = wr_en && (wr_ofs == OFS_LAST);
            if (w_end) w_next = W_IDLE;
         end
         W_DROP: begin
            wr_rdy = 1'b1;
            w_end  = wr_en && (wr_ofs == OFS_LAST);
            if (w_end) w_next = W_IDLE;
         end
         default: w_next = W_IDLE;
      endcase
   end

   assign frame_commit = w_end && (w_state == W_FILL);
   assign frame_drop   = w_end && (w_state == W_DROP);

   always_comb begin
      r_next  = r_state;
      r_issue = 1'b0;
      r_end   = 1'b0;
      unique case (r_state)
         R_IDLE: begin
            if (rd_en && (frames_avail != '0)) begin
               r_issue = 1'b1;
               r_next  = R_READ;
            end
         end
         R_READ: begin
            if (rd_en) begin
               r_issue = 1'b1;
               r_end   = (rd_ofs == OFS_LAST);
               if (r_end) r_next = R_IDLE;
            end
         end
         default: r_next = R_IDLE;
      endcase
   end

   always_ff @(posedge wr_clk) begin
      if (w_store) mem[wr_addr] <= wr_data;
   end

   always_ff @(posedge wr_clk) begin
      if (reset) begin
         w_state       <= W_IDLE;
         wr_idx        <= '0;
         wr_ofs        <= '0;
         wr_frame_done <= 1'b0;
         drop_cnt      <= '0;
      end else begin
         w_state       <= w_next;
         wr_frame_done <= frame_commit;
         if (wr_en && wr_rdy) begin
            wr_ofs <= w_end ? '0 : wr_ofs + OFS_W'(1);
         end
         if (frame_commit) begin
            wr_idx <= (wr_idx == IDX_LAST) ? '0 : wr_idx + IDX_W'(1);
         end
         if (frame_drop && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
         end
      end
   end

   always_ff @(posedge wr_clk) begin
      if (reset) begin
         r_state  <= R_IDLE;
         rd_idx   <= '0;
         rd_ofs   <= '0;
         rd_valid <= 1'b0;
         rd_last  <= 1'b0;
         rd_data  <= '0;
      end else begin
         r_state  <= r_next;
         rd_valid <= r_issue;
         rd_last  <= r_end;
         if (r_issue) begin
            rd_data <= mem[rd_addr];
            rd_ofs  <= r_end ? '0 : rd_ofs + OFS_W'(1);
         end
         if (r_end) begin
            rd_idx <= (rd_idx == IDX_LAST) ? '0 : rd_idx + IDX_W'(1);
         end
      end
   end

   // Commit and release in the same cycle cancel out.
   always_ff @(posedge wr_clk) begin
      if (reset) begin
         frames_avail <= '0;
      end else if (frame_commit && !r_end) begin
         frames_avail <= frames_avail + CNT_W'(1);
      end else if (r_end && !frame_commit) begin
         frames_avail <= frames_avail - CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_frame_buf_multi.sv
// Bench for frame_buf_multi: a stalling and a dropping instance on shared
// stimulus, checked against a queue-based frame model.
module tb_frame_buf_multi;

   localparam int DW = 32;
   localparam int BS = 4;
   localparam int NB = 2;
   localparam int CW = 2;

   logic          wr_clk  = 1'b0;
   logic          reset   = 1'b0;
   logic          wr_en   = 1'b0;
   logic [DW-1:0] wr_data = '0;
   logic          rd_en   = 1'b0;

   logic          wr_rdy_a, wr_frame_done_a, rd_rdy_a, rd_valid_a, rd_last_a;
   logic [DW-1:0] rd_data_a;
   logic [CW-1:0] frames_avail_a;
   logic [15:0]   drop_cnt_a;
   logic          wr_rdy_b, wr_frame_done_b, rd_rdy_b, rd_valid_b, rd_last_b;
   logic [DW-1:0] rd_data_b;
   logic [CW-1:0] frames_avail_b;
   logic [15:0]   drop_cnt_b;

   int n_vec = 0;
   int n_err = 0;

   // model of the stalling instance: committed words and the open frame
   logic [DW-1:0] fifo[$];
   logic [DW-1:0] pend[$];
   int            avail   = 0;
   int            rpos    = 0;
   bit            open_w  = 1'b0;
   bit            reading = 1'b0;
   bit            x_wrdy, x_rrdy, e_valid, e_last, e_done;
   logic [DW-1:0] e_data = '0;
   bit            pre_wrdy_a, pre_rrdy_a, pre_wrdy_b, acc_a, acc_b;

   frame_buf_multi #(.DATA_WIDTH(DW), .BUF_SIZE(BS), .NUM_BUFS(NB),
                     .DROP_MODE(0)) dut_a (
      .wr_clk(wr_clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
      .wr_rdy(wr_rdy_a), .wr_frame_done(wr_frame_done_a), .rd_en(rd_en),
      .rd_rdy(rd_rdy_a), .rd_data(rd_data_a), .rd_valid(rd_valid_a),
      .rd_last(rd_last_a), .frames_avail(frames_avail_a),
      .drop_cnt(drop_cnt_a));

   frame_buf_multi #(.DATA_WIDTH(DW), .BUF_SIZE(BS), .NUM_BUFS(NB),
                     .DROP_MODE(1)) dut_b (
      .wr_clk(wr_clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
      .wr_rdy(wr_rdy_b), .wr_frame_done(wr_frame_done_b), .rd_en(rd_en),
      .rd_rdy(rd_rdy_b), .rd_data(rd_data_b), .rd_valid(rd_valid_b),
      .rd_last(rd_last_b), .frames_avail(frames_avail_b),
      .drop_cnt(drop_cnt_b));

   always #5 wr_clk = ~wr_clk;

   task automatic cycle(input bit we, input logic [DW-1:0] wd, input bit re);
      bit com, rel;
      wr_en   = we;
      wr_data = wd;
      rd_en   = re;
      x_wrdy  = open_w || (avail < NB);
      x_rrdy  = (avail != 0) || reading;
      @(negedge wr_clk);
      pre_wrdy_a = wr_rdy_a;
      pre_rrdy_a = rd_rdy_a;
      pre_wrdy_b = wr_rdy_b;
      acc_a = we && wr_rdy_a;
      acc_b = we && wr_rdy_b;
      @(posedge wr_clk);
      com = 1'b0;
      rel = 1'b0;
      e_valid = 1'b0;
      e_last  = 1'b0;
      e_done  = 1'b0;
      if (reset) begin
         fifo.delete();
         pend.delete();
         avail = 0; rpos = 0; open_w = 1'b0; reading = 1'b0;
         e_data = '0;
      end else begin
         if (re && x_rrdy) begin
            e_valid = 1'b1;
            e_data  = fifo[rpos];
            if (rpos == BS - 1) begin
               e_last = 1'b1; rel = 1'b1; reading = 1'b0; rpos = 0;
               repeat (BS) void'(fifo.pop_front());
            end else begin
               reading = 1'b1; rpos++;
            end
         end
         if (!open_w && (avail < NB)) open_w = 1'b1;
         if (we && x_wrdy) begin
            pend.push_back(wd);
            if (pend.size() == BS) begin
               foreach (pend[i]) fifo.push_back(pend[i]);
               pend.delete();
               open_w = 1'b0; com = 1'b1; e_done = 1'b1;
            end
         end
         avail = avail + int'(com) - int'(rel);
      end
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cycle(1'b0, '0, 1'b0);
      reset = 1'b0;
   endtask

   task automatic write_frame(input int base, input bit on_b);
      int k = 0;
      int guard = 0;
      while (k < BS && guard < 40) begin
         cycle(1'b1, DW'(base + k), 1'b0);
         if (on_b ? acc_b : acc_a) k++;
         guard++;
      end
      n_vec++;
      if (k != BS) begin
         n_err++;
         $display("FAIL write_timeout base %0d: accepted %0d want %0d", base, k, BS);
      end
   endtask

   task automatic read_words(input int n, input int first, input bit on_b);
      int k = 0;
      int guard = 0;
      logic v, l;
      logic [DW-1:0] d;
      while (k < n && guard < 4 * n + 8) begin
         cycle(1'b0, '0, 1'b1);
         v = on_b ? rd_valid_b : rd_valid_a;
         l = on_b ? rd_last_b : rd_last_a;
         d = on_b ? rd_data_b : rd_data_a;
         if (v) begin
            n_vec++;
            if (d !== DW'(first + k) || l !== ((k % BS) == BS - 1)) begin
               n_err++;
               $display("FAIL read_word dut%0d #%0d: got %0d last %0b want %0d last %0b",
                        on_b, k, d, l, first + k, (k % BS) == BS - 1);
            end
            k++;
         end
         guard++;
      end
      n_vec++;
      if (k != n) begin
         n_err++;
         $display("FAIL read_timeout dut%0d: got %0d words want %0d", on_b, k, n);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      cycle(1'b0, '0, 1'b0);
      cycle(1'b0, '0, 1'b0);
      reset = 1'b0;
      n_vec++;
      if (frames_avail_a !== 2'd0 || frames_avail_b !== 2'd0) begin
         n_err++;
         $display("FAIL reset_avail: got %0d/%0d want 0", frames_avail_a, frames_avail_b);
      end
      n_vec++;
      if (drop_cnt_a !== 16'd0 || drop_cnt_b !== 16'd0) begin
         n_err++;
         $display("FAIL reset_drop: got %0d/%0d want 0", drop_cnt_a, drop_cnt_b);
      end
      n_vec++;
      if ({rd_valid_a, rd_last_a, wr_frame_done_a, rd_valid_b} !== 4'b0) begin
         n_err++;
         $display("FAIL reset_flags: got %b want 0000",
                  {rd_valid_a, rd_last_a, wr_frame_done_a, rd_valid_b});
      end
      n_vec++;
      if (rd_data_a !== '0) begin
         n_err++;
         $display("FAIL reset_data: got %0h want 0", rd_data_a);
      end
      n_vec++;
      if (wr_rdy_a !== 1'b1 || rd_rdy_a !== 1'b0) begin
         n_err++;
         $display("FAIL reset_rdy: got wr %b rd %b want wr 1 rd 0", wr_rdy_a, rd_rdy_a);
      end
   endtask

   task automatic test_single_frame();
      do_reset();
      write_frame(1, 1'b0);
      n_vec++;
      if (wr_frame_done_a !== 1'b1 || frames_avail_a !== 2'd1) begin
         n_err++;
         $display("FAIL single_commit: got done %b avail %0d want 1 1",
                  wr_frame_done_a, frames_avail_a);
      end
      cycle(1'b0, '0, 1'b0);
      n_vec++;
      if (wr_frame_done_a !== 1'b0) begin
         n_err++;
         $display("FAIL single_pulse: got done %b want 0", wr_frame_done_a);
      end
      for (int k = 0; k < 5; k++) begin
         cycle(1'b0, '0, 1'b1);
         n_vec++;
         if (rd_valid_a !== (k < 4) ||
             (k < 4 && (rd_data_a !== DW'(k + 1) || rd_last_a !== (k == 3)))) begin
            n_err++;
            $display("FAIL single_read %0d: got v %b d %0d l %b want v %b d %0d l %b",
                     k, rd_valid_a, rd_data_a, rd_last_a, k < 4, k + 1, k == 3);
         end
      end
      n_vec++;
      if (frames_avail_a !== 2'd0) begin
         n_err++;
         $display("FAIL single_drain: got avail %0d want 0", frames_avail_a);
      end
   endtask

   task automatic test_stall();
      do_reset();
      write_frame(1, 1'b0);
      write_frame(5, 1'b0);
      cycle(1'b0, '0, 1'b0);
      n_vec++;
      if (wr_rdy_a !== 1'b0 || frames_avail_a !== 2'd2) begin
         n_err++;
         $display("FAIL stall_full: got rdy %b avail %0d want 0 2", wr_rdy_a, frames_avail_a);
      end
      for (int k = 0; k < 3; k++) begin
         cycle(1'b1, DW'(9), 1'b0);
         n_vec++;
         if (pre_wrdy_a !== 1'b0) begin
            n_err++;
            $display("FAIL stall_hold %0d: got rdy %b want 0", k, pre_wrdy_a);
         end
      end
      read_words(4, 1, 1'b0);
      n_vec++;
      if (wr_rdy_a !== 1'b1) begin
         n_err++;
         $display("FAIL stall_resume: got rdy %b want 1", wr_rdy_a);
      end
      write_frame(9, 1'b0);
      read_words(8, 5, 1'b0);
   endtask

   task automatic test_drop();
      do_reset();
      write_frame(1, 1'b1);
      write_frame(5, 1'b1);
      for (int k = 0; k < BS; k++) begin
         cycle(1'b1, DW'(9 + k), 1'b0);
         n_vec++;
         if (pre_wrdy_b !== 1'b1) begin
            n_err++;
            $display("FAIL drop_rdy %0d: got rdy %b want 1", k, pre_wrdy_b);
         end
      end
      cycle(1'b0, '0, 1'b0);
      n_vec++;
      if (drop_cnt_b !== 16'd1 || frames_avail_b !== 2'd2) begin
         n_err++;
         $display("FAIL drop_count: got drop %0d avail %0d want 1 2", drop_cnt_b, frames_avail_b);
      end
      read_words(4, 1, 1'b1);
      read_words(4, 5, 1'b1);
      n_vec++;
      if (frames_avail_b !== 2'd0 || drop_cnt_b !== 16'd1) begin
         n_err++;
         $display("FAIL drop_drain: got avail %0d drop %0d want 0 1", frames_avail_b, drop_cnt_b);
      end
   endtask

   task automatic test_concurrent();
      do_reset();
      write_frame(100, 1'b0);
      cycle(1'b0, '0, 1'b0);
      for (int k = 0; k < BS; k++) begin
         cycle(1'b1, DW'(200 + k), 1'b1);
         n_vec++;
         if (rd_valid_a !== 1'b1 || rd_data_a !== DW'(100 + k) || frames_avail_a !== 2'd1) begin
            n_err++;
            $display("FAIL conc_read %0d: got v %b d %0d avail %0d want 1 %0d 1",
                     k, rd_valid_a, rd_data_a, frames_avail_a, 100 + k);
         end
      end
      n_vec++;
      if (wr_frame_done_a !== 1'b1 || rd_last_a !== 1'b1) begin
         n_err++;
         $display("FAIL conc_same_cycle: got done %b last %b want 1 1", wr_frame_done_a, rd_last_a);
      end
      read_words(4, 200, 1'b0);
   endtask

   task automatic test_mid_reset();
      do_reset();
      write_frame(1, 1'b0);
      cycle(1'b0, '0, 1'b0);
      cycle(1'b1, DW'(50), 1'b1);
      cycle(1'b1, DW'(51), 1'b1);
      reset = 1'b1;
      cycle(1'b0, '0, 1'b0);
      reset = 1'b0;
      n_vec++;
      if (frames_avail_a !== 2'd0 || rd_valid_a !== 1'b0 ||
          wr_rdy_a !== 1'b1 || rd_rdy_a !== 1'b0) begin
         n_err++;
         $display("FAIL midrst_state: got avail %0d v %b wr %b rd %b want 0 0 1 0",
                  frames_avail_a, rd_valid_a, wr_rdy_a, rd_rdy_a);
      end
      write_frame(20, 1'b0);
      cycle(1'b0, '0, 1'b0);
      read_words(4, 20, 1'b0);
   endtask

   task automatic test_rd_pulse();
      bit re;
      do_reset();
      for (int k = 0; k < 2; k++) begin
         cycle(1'b0, '0, 1'b1);
         n_vec++;
         if (rd_valid_a !== 1'b0) begin
            n_err++;
            $display("FAIL pulse_empty %0d: got v %b want 0", k, rd_valid_a);
         end
      end
      write_frame(40, 1'b0);
      cycle(1'b0, '0, 1'b0);
      for (int k = 0; k < 2 * BS; k++) begin
         re = (k % 2) == 0;
         cycle(1'b0, '0, re);
         n_vec++;
         if (rd_valid_a !== re ||
             (re && (rd_data_a !== DW'(40 + k / 2) || rd_last_a !== (k == 2 * BS - 2)))) begin
            n_err++;
            $display("FAIL pulse_read %0d: got v %b d %0d l %b want v %b d %0d",
                     k, rd_valid_a, rd_data_a, rd_last_a, re, 40 + k / 2);
         end
      end
      cycle(1'b0, '0, 1'b1);
      n_vec++;
      if (rd_valid_a !== 1'b0 || frames_avail_a !== 2'd0) begin
         n_err++;
         $display("FAIL pulse_after: got v %b avail %0d want 0 0", rd_valid_a, frames_avail_a);
      end
   endtask

   task automatic test_random();
      bit we, re;
      do_reset();
      for (int n = 0; n < 600; n++) begin
         we = $urandom_range(0, 99) < 60;
         re = $urandom_range(0, 99) < 55;
         cycle(we, DW'($urandom), re);
         n_vec++;
         if (pre_wrdy_a !== x_wrdy || pre_rrdy_a !== x_rrdy) begin
            n_err++;
            $display("FAIL rand_rdy %0d: got wr %b rd %b want wr %b rd %b",
                     n, pre_wrdy_a, pre_rrdy_a, x_wrdy, x_rrdy);
         end
         n_vec++;
         if (rd_valid_a !== e_valid || (e_valid && (rd_data_a !== e_data || rd_last_a !== e_last))) begin
            n_err++;
            $display("FAIL rand_read %0d: got v %b d %0h l %b want v %b d %0h l %b",
                     n, rd_valid_a, rd_data_a, rd_last_a, e_valid, e_data, e_last);
         end
         n_vec++;
         if (wr_frame_done_a !== e_done || frames_avail_a !== CW'(avail)) begin
            n_err++;
            $display("FAIL rand_count %0d: got done %b avail %0d want %b %0d",
                     n, wr_frame_done_a, frames_avail_a, e_done, avail);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_stall();
      test_drop();
      test_concurrent();
      test_mid_reset();
      test_rd_pulse();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
